// File: rtl/min_window_2b_pkg.sv
// Shared widths and state encodings for the 2-bit running-minimum window tracker.
package min_window_2b_pkg;
  localparam int DATA_W = 2;
  localparam int IDX_W  = 4;
  localparam int CNT_W  = 5;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;
endpackage

// File: rtl/menor_2b2b.sv
// 2-bit unsigned less-than comparator: lt = {a,b} < {c,d}, with a and c the MSBs.
module menor_2b2b (
  input  logic a,
  input  logic b,
  input  logic c,
  input  logic d,
  output logic lt
);
  // Less when the MSB alone decides, or MSBs match and the LSB decides.
  assign lt = (~a & c) | (~(a ^ c) & ~b & d);
endmodule

// File: rtl/min_window_2b.sv
// Running-minimum tracker over a window of 2-bit samples, with the first index of the
// minimum and the window length presented on a registered output handshake.
module min_window_2b
  import min_window_2b_pkg::*;
#(
  parameter int MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_min,
  output logic [IDX_W-1:0]  out_idx,
  output logic [CNT_W-1:0]  out_count
);

  state_t             state_reg, state_next;
  logic [DATA_W-1:0]  min_reg, min_next;
  logic [IDX_W-1:0]   idx_reg, idx_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [DATA_W-1:0]  out_min_reg;
  logic [IDX_W-1:0]   out_idx_reg;
  logic [CNT_W-1:0]   out_count_reg;
  logic               accept;
  logic               close;
  logic               less;

  menor_2b2b u_cmp (
    .a  (in_data[1]),
    .b  (in_data[0]),
    .c  (min_reg[1]),
    .d  (min_reg[0]),
    .lt (less)
  );

  // Ready is a pure decode of the state register, so out_ready never reaches it combinationally.
  assign in_ready  = (state_reg != ST_HOLD);
  assign out_valid = (state_reg == ST_HOLD);
  assign accept    = in_valid && in_ready;

  assign out_min   = out_min_reg;
  assign out_idx   = out_idx_reg;
  assign out_count = out_count_reg;

  always_comb begin
    state_next = state_reg;
    min_next   = min_reg;
    idx_next   = idx_reg;
    count_next = count_reg;
    close      = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (accept) begin
          min_next   = in_data;
          idx_next   = '0;
          count_next = CNT_W'(1);
          close      = in_last;
          state_next = in_last ? ST_HOLD : ST_ACC;
        end
      end
      ST_ACC: begin
        if (accept) begin
          // Strict less-than: a tie keeps the earlier index.
          if (less) begin
            min_next = in_data;
            idx_next = count_reg[IDX_W-1:0];
          end
          count_next = count_reg + CNT_W'(1);
          close      = in_last || (count_next == CNT_W'(MAX_LEN));
          state_next = close ? ST_HOLD : ST_ACC;
        end
      end
      ST_HOLD: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= ST_IDLE;
      min_reg       <= '0;
      idx_reg       <= '0;
      count_reg     <= '0;
      out_min_reg   <= '0;
      out_idx_reg   <= '0;
      out_count_reg <= '0;
    end else begin
      state_reg <= state_next;
      min_reg   <= min_next;
      idx_reg   <= idx_next;
      count_reg <= count_next;
      // Result registers load only on the closing accept and otherwise hold their last value.
      if (close) begin
        out_min_reg   <= min_next;
        out_idx_reg   <= idx_next;
        out_count_reg <= count_next;
      end
    end
  end

endmodule

// File: tb/tb_min_window_2b.sv
// Directed bench for min_window_2b with a window-list reference model checked every cycle.
module tb_min_window_2b;
  localparam int MAX_LEN = 16;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [1:0] in_data;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_min;
  logic [3:0] out_idx;
  logic [4:0] out_count;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model state: samples of the open window and the last closed result.
  int win[MAX_LEN];
  int wlen;
  bit m_hold;
  int e_min, e_idx, e_cnt;

  always #5 clk = ~clk;

  min_window_2b #(.MAX_LEN(MAX_LEN)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_min   (out_min),
    .out_idx   (out_idx),
    .out_count (out_count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_hold = 1'b0;
      wlen   = 0;
      e_min  = 0;
      e_idx  = 0;
      e_cnt  = 0;
    end else if (m_hold) begin
      if (out_ready) m_hold = 1'b0;
    end else if (in_valid) begin
      win[wlen] = int'(in_data);
      wlen++;
      if (in_last || wlen == MAX_LEN) begin
        e_min = 3;
        for (int i = 0; i < wlen; i++) if (win[i] < e_min) e_min = win[i];
        e_idx = -1;
        for (int i = 0; i < wlen; i++) if (e_idx < 0 && win[i] == e_min) e_idx = i;
        e_cnt  = wlen;
        m_hold = 1'b1;
        wlen   = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en && !rst) begin
      check("model_in_ready", in_ready, !m_hold);
      check("model_out_valid", out_valid, m_hold);
      check("model_out_min", out_min, e_min);
      check("model_out_idx", out_idx, e_idx);
      check("model_out_count", out_count, e_cnt);
    end
  end

  // Called just after a falling edge; returns just after the falling edge following the accept.
  task automatic send(input logic [1:0] d, input logic l);
    int t;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    t = 0;
    while (!in_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("send_timeout", 0, 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 2'd0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_result(input string name, input int mn, input int ix, input int cnt);
    check({name, "_valid"}, out_valid, 1);
    check({name, "_min"}, out_min, mn);
    check({name, "_idx"}, out_idx, ix);
    check({name, "_count"}, out_count, cnt);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = 2'd0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    idle(2);
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_min", out_min, 0);
    check("reset_out_idx", out_idx, 0);
    check("reset_out_count", out_count, 0);
    cmp_en = 1'b1;

    // Basic window 3,2,3,1,2
    send(2'd3, 0); send(2'd2, 0); send(2'd3, 0); send(2'd1, 0);
    check("basic_no_early_valid", out_valid, 0);
    send(2'd2, 1);
    expect_result("basic", 1, 3, 5);
    $display("basic window: min=%0d idx=%0d count=%0d", out_min, out_idx, out_count);
    idle(1);
    check("basic_valid_one_cycle", out_valid, 0);

    // Ties and first-sample minimum
    send(2'd0, 0); send(2'd0, 0); send(2'd2, 0); send(2'd0, 1);
    expect_result("ties", 0, 0, 4);
    $display("ties window: min=%0d idx=%0d count=%0d", out_min, out_idx, out_count);
    send(2'd2, 1);
    expect_result("single", 2, 0, 1);
    $display("single window: min=%0d idx=%0d count=%0d", out_min, out_idx, out_count);

    // Forced close at MAX_LEN, 17th beat opens a new window
    for (int i = 0; i < MAX_LEN; i++) send(2'd3, 0);
    expect_result("forced", 3, 0, 16);
    $display("forced window: min=%0d idx=%0d count=%0d", out_min, out_idx, out_count);
    send(2'd1, 1);
    expect_result("after_forced", 1, 0, 1);
    $display("after forced window: min=%0d idx=%0d count=%0d", out_min, out_idx, out_count);

    // Backpressure in HOLD
    idle(1);
    out_ready = 1'b0;
    send(2'd1, 0); send(2'd2, 1);
    for (int i = 0; i < 5; i++) begin
      expect_result("bp_hold", 1, 0, 2);
      check("bp_in_ready_low", in_ready, 0);
      idle(1);
    end
    out_ready = 1'b1;
    idle(1);
    check("bp_release_in_ready", in_ready, 1);
    check("bp_release_out_valid", out_valid, 0);
    $display("backpressure window released: min=%0d idx=%0d count=%0d", out_min, out_idx, out_count);

    // Bubbles between samples
    send(2'd2, 0); idle(1); send(2'd1, 0); idle(1); send(2'd3, 1);
    expect_result("bubbles", 1, 1, 3);
    $display("bubble window: min=%0d idx=%0d count=%0d", out_min, out_idx, out_count);

    // Asynchronous reset mid-window, between clock edges
    send(2'd3, 0); send(2'd1, 0); send(2'd2, 0);
    #2 rst = 1'b1;
    #1;
    check("arst_out_valid", out_valid, 0);
    check("arst_out_min", out_min, 0);
    check("arst_out_idx", out_idx, 0);
    check("arst_out_count", out_count, 0);
    check("arst_in_ready", in_ready, 1);
    $display("async reset applied mid-window");
    @(negedge clk);
    rst = 1'b0;
    send(2'd1, 0); send(2'd0, 1);
    expect_result("post_reset", 0, 1, 2);
    $display("post-reset window: min=%0d idx=%0d count=%0d", out_min, out_idx, out_count);
    idle(2);

    cmp_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
